sys_array_stream_fetcher: RTL and testbench

Streaming front/back end for `sys_array_basic` with handshakes on both sides. It holds a stationary B (weight) matrix and accepts a runtime number of A rows over a valid/ready input. It skews each row into the array, de-skews the array outputs, and buffers result rows in an output FIFO. A credit counter prevents the free-running array from overflowing that FIFO under output backpressure. It replaces the fixed-size, single-shot fetch for jobs with row count up to `MAX_ROWS`.

---
 rtl/sys_array_stream_fetcher.sv | 215 +++++++++++++++++++++
 tb/tb_sys_array_stream_fetcher.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_stream_fetcher.sv
// Streaming wrapper around a weight-stationary systolic array. It skews A rows into the array,
// de-skews the result rows, and buffers them in a credit-protected first-word-fall-through FIFO.
module sys_array_stream_fetcher #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int OUT_DEPTH  = 4,
  parameter int MAX_ROWS   = 255,
  localparam int CNT_W     = $clog2(MAX_ROWS + 1)
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         cfg_load,
  input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] cfg_weights,
  input  logic                                         start,
  input  logic [CNT_W-1:0]                             row_count,
  input  logic                                         a_valid,
  output logic                                         a_ready,
  input  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]           a_data,
  output logic                                         r_valid,
  input  logic                                         r_ready,
  output logic [0:ARRAY_W-1][2*DATA_WIDTH-1:0]         r_data,
  output logic                                         r_last,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         weights_valid,
  output logic                                         err
);
  // Array latency is fixed by the PE structure: ARRAY_L psum stages plus one output register.
  localparam int ARRAY_LAT = ARRAY_L + 1;
  localparam int PW        = 2 * DATA_WIDTH;
  localparam int TOK_LEN   = 1 + ARRAY_LAT + ARRAY_W - 1;
  localparam int FW        = $clog2(OUT_DEPTH + 1);
  localparam int AW        = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                                          state_q, state_d;
  logic [CNT_W-1:0]                                row_cnt_q, row_cnt_d, acc_cnt_q, acc_cnt_d;
  logic                                            wv_q, wv_d, done_q, done_d, err_q, err_d;
  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] w_q, w_d;

  logic [DATA_WIDTH-1:0] sk_q  [ARRAY_L][ARRAY_L], sk_d  [ARRAY_L][ARRAY_L];
  logic [DATA_WIDTH-1:0] ap_q  [ARRAY_L][ARRAY_W], ap_d  [ARRAY_L][ARRAY_W];
  logic [PW-1:0]         ps_q  [ARRAY_L][ARRAY_W], ps_d  [ARRAY_L][ARRAY_W];
  logic [PW-1:0]         out_q [ARRAY_W],          out_d [ARRAY_W];
  logic [PW-1:0]         dsk_q [ARRAY_W][ARRAY_W], dsk_d [ARRAY_W][ARRAY_W];
  logic [1:0]            tok_q [TOK_LEN],          tok_d [TOK_LEN];
  logic [0:ARRAY_W-1][PW-1:0] aligned;

  logic                       wr_en_q, wr_en_d, wr_last_q, wr_last_d;
  logic [0:ARRAY_W-1][PW-1:0] wr_data_q, wr_data_d;
  logic [0:ARRAY_W-1][PW-1:0] mem_q [OUT_DEPTH], mem_d [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]       mlast_q, mlast_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]              fifo_cnt_q, fifo_cnt_d, infl_q, infl_d;

  logic acc, last_acc, pop, push, credit_ok, row_ok;

  assign credit_ok = (fifo_cnt_q + infl_q) < FW'(OUT_DEPTH);
  assign a_ready   = (state_q == RUN) && (acc_cnt_q < row_cnt_q) && credit_ok;
  assign acc       = a_valid && a_ready;
  assign last_acc  = (acc_cnt_q + CNT_W'(1)) == row_cnt_q;
  assign row_ok    = (row_count != '0) && ({1'b0, row_count} <= (CNT_W + 1)'(MAX_ROWS));
  assign push      = wr_en_q;
  assign pop       = r_valid && r_ready;

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = done_q;
  assign err           = err_q;
  assign weights_valid = wv_q;
  assign r_valid       = fifo_cnt_q != '0;
  assign r_data        = r_valid ? mem_q[rd_ptr_q] : '0;
  assign r_last        = r_valid && mlast_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    acc_cnt_d = acc_cnt_q;
    wv_d      = wv_q;
    w_d       = w_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          state_d = LOAD;
          w_d     = cfg_weights;
          err_d   = start;
        end else if (start) begin
          if (wv_q && row_ok) begin
            state_d   = RUN;
            row_cnt_d = row_count;
            acc_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        wv_d    = 1'b1;
        state_d = IDLE;
        err_d   = cfg_load || start;
      end
      RUN: begin
        err_d = cfg_load || start;
        if (acc) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (last_acc) state_d = DRAIN;
        end
      end
      DRAIN: begin
        err_d = cfg_load || start;
        if (wr_en_q && wr_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skew, PE grid, de-skew and token chain; bubbles enter as all-zero lanes with a 0 token.
  always_comb begin
    for (int k = 0; k < ARRAY_L; k++) begin
      sk_d[k][0] = acc ? a_data[k] : '0;
      for (int s = 1; s < ARRAY_L; s++) sk_d[k][s] = sk_q[k][s-1];
    end
    for (int k = 0; k < ARRAY_L; k++) begin
      ap_d[k][0] = sk_q[k][k];
      for (int j = 1; j < ARRAY_W; j++) ap_d[k][j] = ap_q[k][j-1];
    end
    for (int j = 0; j < ARRAY_W; j++) begin
      ps_d[0][j] = PW'(ap_d[0][j]) * PW'(w_q[j][0]);
      for (int k = 1; k < ARRAY_L; k++)
        ps_d[k][j] = ps_q[k-1][j] + PW'(ap_d[k][j]) * PW'(w_q[j][k]);
      out_d[j]    = ps_q[ARRAY_L-1][j];
      dsk_d[j][0] = out_q[j];
      for (int s = 1; s < ARRAY_W; s++) dsk_d[j][s] = dsk_q[j][s-1];
    end
    for (int j = 0; j < ARRAY_W - 1; j++) aligned[j] = dsk_q[j][ARRAY_W-2-j];
    aligned[ARRAY_W-1] = out_q[ARRAY_W-1];
    tok_d[0] = {acc, acc && last_acc};
    for (int i = 1; i < TOK_LEN; i++) tok_d[i] = tok_q[i-1];
    wr_en_d   = tok_q[TOK_LEN-1][1];
    wr_last_d = tok_q[TOK_LEN-1][0];
    wr_data_d = tok_q[TOK_LEN-1][1] ? aligned : '0;
  end

  always_comb begin
    mem_d      = mem_q;
    mlast_d    = mlast_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q]   = wr_data_q;
      mlast_d[wr_ptr_q] = wr_last_q;
      wr_ptr_d = (wr_ptr_q == AW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == AW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    fifo_cnt_d = fifo_cnt_q + FW'(push) - FW'(pop);
    infl_d     = infl_q + FW'(acc) - FW'(push);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      acc_cnt_q  <= '0;
      wv_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      w_q        <= '0;
      sk_q       <= '{default: '0};
      ap_q       <= '{default: '0};
      ps_q       <= '{default: '0};
      out_q      <= '{default: '0};
      dsk_q      <= '{default: '0};
      tok_q      <= '{default: '0};
      wr_en_q    <= 1'b0;
      wr_last_q  <= 1'b0;
      wr_data_q  <= '0;
      mem_q      <= '{default: '0};
      mlast_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      infl_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      wv_q       <= wv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      w_q        <= w_d;
      sk_q       <= sk_d;
      ap_q       <= ap_d;
      ps_q       <= ps_d;
      out_q      <= out_d;
      dsk_q      <= dsk_d;
      tok_q      <= tok_d;
      wr_en_q    <= wr_en_d;
      wr_last_q  <= wr_last_d;
      wr_data_q  <= wr_data_d;
      mem_q      <= mem_d;
      mlast_q    <= mlast_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      infl_q     <= infl_d;
    end
  end

endmodule

// File: tb/tb_sys_array_stream_fetcher.sv
// Randomized bench for sys_array_stream_fetcher; results are predicted by a plain matrix-product
// model and an expected-row queue, independent of the design's pipeline structure.
module tb_sys_array_stream_fetcher;
  localparam int DW = 8, W = 4, L = 4, OD = 4, MR = 255, CW = 8;

  typedef logic [0:W-1][0:L-1][DW-1:0] wmat_t;
  typedef logic [0:L-1][DW-1:0]        arow_t;
  typedef struct { logic [63:0] d; logic l; } exp_t;

  logic clk = 1'b0;
  logic reset_n, cfg_load, start, a_valid, a_ready, r_valid, r_ready, r_last;
  logic busy, done, weights_valid, err;
  wmat_t cfg_weights;
  logic [CW-1:0] row_count;
  arow_t a_data;
  logic [0:W-1][2*DW-1:0] r_data;

  always #5 clk = ~clk;

  sys_array_stream_fetcher #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L), .OUT_DEPTH(OD),
                             .MAX_ROWS(MR)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_weights(cfg_weights),
    .start(start), .row_count(row_count), .a_valid(a_valid), .a_ready(a_ready),
    .a_data(a_data), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_last(r_last), .busy(busy), .done(done), .weights_valid(weights_valid), .err(err));

  int n_chk = 0, n_err = 0, cyc = 0;
  int job_n = 0, sent = 0, done_cnt = 0, first_acc = -1, first_rv = -1;
  wmat_t wm;
  arow_t rows [16];
  exp_t exp_q[$];
  logic [63:0] last_pop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic logic [63:0] model(input arow_t a);
    logic [0:W-1][15:0] e;
    int s;
    for (int j = 0; j < W; j++) begin
      s = 0;
      for (int k = 0; k < L; k++) s += int'(a[k]) * int'(wm[j][k]);
      e[j] = s[15:0];
    end
    return e;
  endfunction

  // Called at the falling edge with inputs set for the coming rising edge.
  task automatic step();
    exp_t e;
    if (a_valid && a_ready) begin
      sent++;
      e.d = model(a_data);
      e.l = (sent == job_n);
      exp_q.push_back(e);
      if (first_acc < 0) first_acc = cyc;
    end
    if (r_valid && first_rv < 0) first_rv = cyc;
    if (r_valid && r_ready) begin
      chk("pop_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("r_data", r_data, e.d);
        chk("r_last", r_last, e.l);
        last_pop = r_data;
      end
    end
    if (done) begin
      done_cnt++;
      chk("busy_low_at_done", busy, 0);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic load_w(input wmat_t w);
    cfg_weights = w; cfg_load = 1; step(); cfg_load = 0; wm = w;
    step();
  endtask

  task automatic start_job(input int n);
    job_n = n; sent = 0; done_cnt = 0;
    start = 1; row_count = CW'(n); step(); start = 0;
  endtask

  task automatic drive_job(input int vpct, input int rpct, input string tag);
    int guard = 0;
    while ((sent < job_n || exp_q.size() != 0 || done_cnt == 0) && guard < 3000) begin
      a_valid = (sent < job_n) && ($urandom_range(99) < vpct);
      a_data  = a_valid ? rows[sent] : arow_t'($urandom);
      r_ready = $urandom_range(99) < rpct;
      step();
      guard++;
    end
    a_valid = 0; r_ready = 0;
    chk({tag, "_no_timeout"}, guard < 3000, 1);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle_after"}, {busy, r_valid}, 0);
  endtask

  function automatic wmat_t rand_w();
    wmat_t w;
    for (int j = 0; j < W; j++) for (int k = 0; k < L; k++) w[j][k] = DW'($urandom);
    return w;
  endfunction

  wmat_t ident;
  int guard;

  initial begin
    reset_n = 0; cfg_load = 0; start = 0; row_count = 0; a_valid = 0; r_ready = 0;
    a_data = '0; cfg_weights = '0; wm = '0; last_pop = '0;
    for (int j = 0; j < W; j++) for (int k = 0; k < L; k++) ident[j][k] = (j == k) ? 8'd1 : 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("reset_ctrl", {a_ready, r_valid, r_last, busy, done, weights_valid, err}, 0);
    chk("reset_data", r_data, 0);

    // Rejected commands
    start = 1; row_count = 3; step(); start = 0;
    chk("err_start_no_weights", {err, busy, weights_valid}, 3'b100);
    step();
    chk("err_one_cycle", err, 0);
    cfg_weights = ident; cfg_load = 1; step(); cfg_load = 0; wm = ident;
    start = 1; row_count = 1; step(); start = 0;
    chk("err_start_in_load", {err, busy, weights_valid}, 3'b101);
    start = 1; row_count = 0; step(); start = 0;
    chk("err_row_count_zero", {err, busy}, 2'b10);
    cfg_load = 1; start = 1; row_count = 3; step(); cfg_load = 0; start = 0;
    chk("err_start_with_load", {err, busy}, 2'b10);
    step();

    // Identity, back-to-back rows
    rows[0] = {8'd1, 8'd2, 8'd3, 8'd4};
    rows[1] = {8'd5, 8'd6, 8'd7, 8'd8};
    rows[2] = {8'd9, 8'd10, 8'd11, 8'd12};
    first_acc = -1; first_rv = -1;
    start_job(3);
    chk("busy_rise", busy, 1);
    drive_job(100, 100, "ident");
    chk("ident_rvalid_latency", first_rv - first_acc, 11);
    chk("ident_last_row", last_pop, {16'd9, 16'd10, 16'd11, 16'd12});

    // Overflow wrap
    load_w({W*L{8'd255}});
    rows[0] = {L{8'd255}};
    start_job(1);
    drive_job(100, 100, "ovf");
    chk("ovf_lane0", last_pop[63:48], 63492);
    chk("ovf_lane3", last_pop[15:0], 63492);

    // Backpressure, plus cfg_load rejected while busy
    load_w(rand_w());
    for (int i = 0; i < 10; i++) rows[i] = arow_t'($urandom);
    start_job(10);
    for (int i = 0; i < 30; i++) begin
      a_valid = 1; a_data = rows[sent]; r_ready = 0; step();
    end
    a_valid = 0;
    chk("bp_accepted", sent, 4);
    chk("bp_a_ready_low", a_ready, 0);
    cfg_weights = rand_w(); cfg_load = 1; step(); cfg_load = 0;
    chk("err_load_while_busy", {err, busy}, 2'b11);
    drive_job(100, 100, "bp");

    // Bubbles and random output stalls
    load_w(rand_w());
    for (int i = 0; i < 6; i++) rows[i] = arow_t'($urandom);
    start_job(6);
    drive_job(50, 70, "bub");

    // Asynchronous reset mid-job
    load_w(rand_w());
    for (int i = 0; i < 5; i++) rows[i] = arow_t'($urandom);
    start_job(5);
    guard = 0;
    while (sent < 2 && guard < 50) begin
      a_valid = 1; a_data = rows[sent]; r_ready = 1; step(); guard++;
    end
    a_valid = 0;
    chk("rst_two_rows_sent", sent, 2);
    #2 reset_n = 0;
    #1;
    chk("rst_async_ctrl", {a_ready, r_valid, r_last, busy, done, weights_valid, err}, 0);
    chk("rst_async_data", r_data, 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1;
    step();
    load_w(rand_w());
    rows[0] = arow_t'($urandom);
    start_job(1);
    drive_job(100, 100, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
